axi4_mst_tgen: RTL

Synthesizable AXI4 initiator that drives the 512-bit DDR AXI4 port from the CL side. It writes a deterministic address-derived pattern over a programmed region, then reads the region back and checks it. It is the initiator counterpart of the DDR slave model and is used for DDR bring-up and bench self-check. It supports one outstanding burst at a time, INCR bursts only, and full 64-byte beats.

---
 rtl/axi4_mst_tgen_if.sv | 59 +++++
 rtl/axi4_mst_tgen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/axi4_mst_tgen_if.sv
// AXI4 512-bit DDR port bundle between the CL-side traffic generator (master) and the shell/DDR model (slave).
interface axi4_mst_tgen_if;
  logic [15:0]  cl_sh_ddr_awid;
  logic [63:0]  cl_sh_ddr_awaddr;
  logic [7:0]   cl_sh_ddr_awlen;
  logic [2:0]   cl_sh_ddr_awsize;
  logic [1:0]   cl_sh_ddr_awburst;
  logic         cl_sh_ddr_awvalid;
  logic         sh_cl_ddr_awready;
  logic [15:0]  cl_sh_ddr_wid;
  logic [511:0] cl_sh_ddr_wdata;
  logic [63:0]  cl_sh_ddr_wstrb;
  logic         cl_sh_ddr_wlast;
  logic         cl_sh_ddr_wvalid;
  logic         sh_cl_ddr_wready;
  logic [15:0]  sh_cl_ddr_bid;
  logic [1:0]   sh_cl_ddr_bresp;
  logic         sh_cl_ddr_bvalid;
  logic         cl_sh_ddr_bready;
  logic [15:0]  cl_sh_ddr_arid;
  logic [63:0]  cl_sh_ddr_araddr;
  logic [7:0]   cl_sh_ddr_arlen;
  logic [2:0]   cl_sh_ddr_arsize;
  logic [1:0]   cl_sh_ddr_arburst;
  logic         cl_sh_ddr_arvalid;
  logic         sh_cl_ddr_arready;
  logic [15:0]  sh_cl_ddr_rid;
  logic [511:0] sh_cl_ddr_rdata;
  logic [1:0]   sh_cl_ddr_rresp;
  logic         sh_cl_ddr_rlast;
  logic         sh_cl_ddr_rvalid;
  logic         cl_sh_ddr_rready;

  modport master (
    output cl_sh_ddr_awid, cl_sh_ddr_awaddr, cl_sh_ddr_awlen, cl_sh_ddr_awsize, cl_sh_ddr_awburst, cl_sh_ddr_awvalid,
    input  sh_cl_ddr_awready,
    output cl_sh_ddr_wid, cl_sh_ddr_wdata, cl_sh_ddr_wstrb, cl_sh_ddr_wlast, cl_sh_ddr_wvalid,
    input  sh_cl_ddr_wready,
    input  sh_cl_ddr_bid, sh_cl_ddr_bresp, sh_cl_ddr_bvalid,
    output cl_sh_ddr_bready,
    output cl_sh_ddr_arid, cl_sh_ddr_araddr, cl_sh_ddr_arlen, cl_sh_ddr_arsize, cl_sh_ddr_arburst, cl_sh_ddr_arvalid,
    input  sh_cl_ddr_arready,
    input  sh_cl_ddr_rid, sh_cl_ddr_rdata, sh_cl_ddr_rresp, sh_cl_ddr_rlast, sh_cl_ddr_rvalid,
    output cl_sh_ddr_rready
  );

  modport slave (
    input  cl_sh_ddr_awid, cl_sh_ddr_awaddr, cl_sh_ddr_awlen, cl_sh_ddr_awsize, cl_sh_ddr_awburst, cl_sh_ddr_awvalid,
    output sh_cl_ddr_awready,
    input  cl_sh_ddr_wid, cl_sh_ddr_wdata, cl_sh_ddr_wstrb, cl_sh_ddr_wlast, cl_sh_ddr_wvalid,
    output sh_cl_ddr_wready,
    output sh_cl_ddr_bid, sh_cl_ddr_bresp, sh_cl_ddr_bvalid,
    input  cl_sh_ddr_bready,
    input  cl_sh_ddr_arid, cl_sh_ddr_araddr, cl_sh_ddr_arlen, cl_sh_ddr_arsize, cl_sh_ddr_arburst, cl_sh_ddr_arvalid,
    output sh_cl_ddr_arready,
    output sh_cl_ddr_rid, sh_cl_ddr_rdata, sh_cl_ddr_rresp, sh_cl_ddr_rlast, sh_cl_ddr_rvalid,
    input  cl_sh_ddr_rready
  );
endinterface

// File: rtl/axi4_mst_tgen.sv
// AXI4 traffic generator: writes an address-derived pattern over a region, reads it back and checks it,
// one INCR burst outstanding at a time. Define AXI_TGEN_RESP_CHK_EN to count bad B/R responses and IDs.
module axi4_mst_tgen #(
  parameter logic [15:0] AXI_ID  = 16'h0000,
  parameter logic [31:0] ERR_SAT = 32'hFFFF_FFFF
) (
  input  logic        clk_core,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [63:0] cfg_base_addr,
  input  logic [7:0]  cfg_len,
  input  logic [15:0] cfg_num_bursts,
  input  logic [31:0] cfg_seed,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic [31:0] err_cnt,
  output logic [63:0] first_err_addr,
  output logic [15:0] resp_err_cnt,
  axi4_mst_tgen_if.master ddr
);

  typedef enum logic [2:0] {S_IDLE, S_WR_AW, S_WR_W, S_WR_B, S_RD_AR, S_RD_R, S_DONE} state_t;

  state_t       state, state_nxt;
  logic [63:0]  base_q, addr_q, beat_addr, stride;
  logic [7:0]   len_q, beat_q;
  logic [15:0]  nb_q, burst_q;
  logic [31:0]  seed_q;
  logic [511:0] exp_dat;
  logic         start_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs, wlast_beat, last_burst, beat_bad;

  function automatic logic [511:0] pattern(input logic [63:0] a, input logic [31:0] s);
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[32*i +: 32] = (a[31:0] + 32'(4 * i)) ^ s;
    return p;
  endfunction

  // Length must be 2^k-1 (k<=6) and the base aligned to the burst size, so no burst crosses 4KB.
  assign start_ok   = ((cfg_len & (cfg_len + 8'd1)) == 8'd0) && (cfg_len[7:6] == 2'b00)
                   && ((cfg_base_addr[13:0] & {cfg_len, 6'h3f}) == 14'd0);
  assign stride     = {50'd0, len_q, 6'd0} + 64'd64;
  assign beat_addr  = addr_q + {50'd0, beat_q, 6'd0};
  assign exp_dat    = pattern(beat_addr, seed_q);
  assign beat_bad   = (ddr.sh_cl_ddr_rdata != exp_dat);
  assign wlast_beat = (beat_q == len_q);
  assign last_burst = (burst_q == nb_q - 16'd1);
  assign aw_hs      = ddr.cl_sh_ddr_awvalid & ddr.sh_cl_ddr_awready;
  assign w_hs       = ddr.cl_sh_ddr_wvalid  & ddr.sh_cl_ddr_wready;
  assign b_hs       = ddr.cl_sh_ddr_bready  & ddr.sh_cl_ddr_bvalid;
  assign ar_hs      = ddr.cl_sh_ddr_arvalid & ddr.sh_cl_ddr_arready;
  assign r_hs       = ddr.cl_sh_ddr_rready  & ddr.sh_cl_ddr_rvalid;

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cfg_start && start_ok) state_nxt = S_WR_AW;
      S_WR_AW: if (aw_hs) state_nxt = S_WR_W;
      S_WR_W:  if (w_hs && wlast_beat) state_nxt = S_WR_B;
      S_WR_B:  if (b_hs) state_nxt = last_burst ? S_RD_AR : S_WR_AW;
      S_RD_AR: if (ar_hs) state_nxt = S_RD_R;
      S_RD_R:  if (r_hs && ddr.sh_cl_ddr_rlast) state_nxt = last_burst ? S_DONE : S_RD_AR;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Payload is forced to zero whenever its valid is low, so reset and idle outputs are all-zero.
  always_comb begin
    ddr.cl_sh_ddr_awid    = '0;
    ddr.cl_sh_ddr_awaddr  = '0;
    ddr.cl_sh_ddr_awlen   = '0;
    ddr.cl_sh_ddr_awsize  = '0;
    ddr.cl_sh_ddr_awburst = '0;
    ddr.cl_sh_ddr_awvalid = 1'b0;
    ddr.cl_sh_ddr_wid     = '0;
    ddr.cl_sh_ddr_wdata   = '0;
    ddr.cl_sh_ddr_wstrb   = '0;
    ddr.cl_sh_ddr_wlast   = 1'b0;
    ddr.cl_sh_ddr_wvalid  = 1'b0;
    ddr.cl_sh_ddr_bready  = 1'b0;
    ddr.cl_sh_ddr_arid    = '0;
    ddr.cl_sh_ddr_araddr  = '0;
    ddr.cl_sh_ddr_arlen   = '0;
    ddr.cl_sh_ddr_arsize  = '0;
    ddr.cl_sh_ddr_arburst = '0;
    ddr.cl_sh_ddr_arvalid = 1'b0;
    ddr.cl_sh_ddr_rready  = 1'b0;
    busy                  = (state != S_IDLE) && (state != S_DONE);
    case (state)
      S_WR_AW: begin
        ddr.cl_sh_ddr_awvalid = 1'b1;
        ddr.cl_sh_ddr_awid    = AXI_ID;
        ddr.cl_sh_ddr_awaddr  = addr_q;
        ddr.cl_sh_ddr_awlen   = len_q;
        ddr.cl_sh_ddr_awsize  = 3'b110;
        ddr.cl_sh_ddr_awburst = 2'b01;
      end
      S_WR_W: begin
        ddr.cl_sh_ddr_wvalid = 1'b1;
        ddr.cl_sh_ddr_wid    = AXI_ID;
        ddr.cl_sh_ddr_wdata  = exp_dat;
        ddr.cl_sh_ddr_wstrb  = '1;
        ddr.cl_sh_ddr_wlast  = wlast_beat;
      end
      S_WR_B: ddr.cl_sh_ddr_bready = 1'b1;
      S_RD_AR: begin
        ddr.cl_sh_ddr_arvalid = 1'b1;
        ddr.cl_sh_ddr_arid    = AXI_ID;
        ddr.cl_sh_ddr_araddr  = addr_q;
        ddr.cl_sh_ddr_arlen   = len_q;
        ddr.cl_sh_ddr_arsize  = 3'b110;
        ddr.cl_sh_ddr_arburst = 2'b01;
      end
      S_RD_R: ddr.cl_sh_ddr_rready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0; addr_q <= '0; len_q <= '0; beat_q <= '0;
      nb_q <= '0; burst_q <= '0; seed_q <= '0;
      done <= 1'b0; cfg_err <= 1'b0; err_cnt <= '0; first_err_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (cfg_start) begin
          if (start_ok) begin
            base_q         <= cfg_base_addr;
            addr_q         <= cfg_base_addr;
            len_q          <= cfg_len;
            nb_q           <= (cfg_num_bursts == 16'd0) ? 16'd1 : cfg_num_bursts;
            seed_q         <= cfg_seed;
            beat_q         <= '0;
            burst_q        <= '0;
            done           <= 1'b0;
            cfg_err        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
          end else begin
            cfg_err <= 1'b1;
          end
        end
        S_WR_W: if (w_hs) beat_q <= wlast_beat ? 8'd0 : beat_q + 8'd1;
        S_WR_B: if (b_hs) begin
          addr_q  <= last_burst ? base_q : addr_q + stride;
          burst_q <= last_burst ? 16'd0 : burst_q + 16'd1;
        end
        S_RD_R: if (r_hs) begin
          if (beat_bad) begin
            if (err_cnt != ERR_SAT) err_cnt <= err_cnt + 32'd1;
            if (err_cnt == 32'd0)   first_err_addr <= beat_addr;
          end
          if (ddr.sh_cl_ddr_rlast) begin
            beat_q  <= '0;
            addr_q  <= addr_q + stride;
            burst_q <= burst_q + 16'd1;
            if (last_burst) done <= 1'b1;
          end else begin
            beat_q <= beat_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AXI_TGEN_RESP_CHK_EN
  logic resp_bad;
  assign resp_bad = (b_hs && (ddr.sh_cl_ddr_bresp != 2'b00 || ddr.sh_cl_ddr_bid != AXI_ID))
                 || (r_hs && (ddr.sh_cl_ddr_rresp != 2'b00 || ddr.sh_cl_ddr_rid != AXI_ID));

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n)                                   resp_err_cnt <= '0;
    else if (state == S_IDLE && cfg_start && start_ok) resp_err_cnt <= '0;
    else if (resp_bad && resp_err_cnt != 16'hFFFF) resp_err_cnt <= resp_err_cnt + 16'd1;
  end
`else
  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) resp_err_cnt <= '0;
    else        resp_err_cnt <= '0;
  end
`endif

endmodule
